l2_write_buffer: RTL and testbench
==================================

Name: l2_write_buffer

Overview:
Parametrised FIFO write-back buffer between the L2 cache and main memory. It accepts dirty-victim evictions from the L2 controller in one cycle and drains them to memory in the background over the mem_write/mem_ready handshake. It gives read-miss forwarding: the L2 can check whether a missed block is still buffered and take its data without a memory read. The L2 controller uses the mem_rd_busy input to give its own refill reads priority on the memory port.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
ADDR_W, 28, block address width
DATA_W, 128, block data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
push  in  1  enqueue eviction this cycle
push_addr  in  ADDR_W  victim block address
push_data  in  DATA_W  victim block data
full  out  1  no free entry (count == DEPTH)
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  occupied entries
overflow  out  1  sticky: a push was dropped
lk_addr  in  ADDR_W  lookup address (L2 read miss)
lk_hit  out  1  a valid entry matches lk_addr
lk_data  out  DATA_W  data of the newest matching entry, 0 if no match
mem_rd_busy  in  1  L2 owns the memory port; no new drain may start
flush  in  1  drain request; level-sensitive
idle  out  1  empty and drain FSM in IDLE
mem_write  out  1  memory write request (registered)
mem_addr  out  ADDR_W  head address (registered)
mem_wdata  out  DATA_W  head data (registered)
mem_ready  in  1  one-cycle memory completion pulse

Behaviour:
- Reset: all entries invalid, write and read pointers = 0, count = 0, full = 0, empty = 1, overflow = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, FSM = IDLE, idle = 1. Reset mid-drain drops every entry and the in-flight write.
- Storage: circular array. wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Push: when push && !full, write {addr, data} at wr_ptr, set its valid bit, increment wr_ptr. When push && full, drop the push and set overflow.
- Same-cycle push and pop: both take effect and count is unchanged. full is evaluated from the registered count, so a push at full is dropped even when a pop completes in the same cycle.
- Drain FSM, two states:
  - IDLE -> WRITE when !empty && !mem_rd_busy. On that edge, mem_write <= 1 and mem_addr/mem_wdata <= head entry.
  - WRITE: hold mem_write, mem_addr and mem_wdata stable until mem_ready. On mem_ready, clear the head valid bit, increment rd_ptr, mem_write <= 0, return to IDLE.
  - The cycle after a pop is always idle (one-cycle gap), so a new drain can start no sooner than 2 cycles after mem_ready.
  - mem_rd_busy rising during WRITE does not abort the write in flight.
  - mem_ready while in IDLE is ignored.
- flush: overrides mem_rd_busy for the start condition while asserted.
- Lookup (combinational):
  - Compares lk_addr against all valid entries, including the head currently in WRITE.
  - On several matches, returns the one nearest wr_ptr (youngest).
  - Sees the registered state only: a same-cycle push is not visible, and a same-cycle pop is still visible.
- Drain throughput: one entry per memory write completion plus the one-cycle gap.

Optional Feature:
WB_COALESCE_EN:
- Defined: a push whose address matches a valid entry that is not the in-flight head (entry at rd_ptr while FSM == WRITE) overwrites that entry's data in place. No new slot is allocated and count is unchanged. This is accepted even when full, so overflow is not set.
- A match only on the in-flight head allocates a new entry normally.
- Undefined: every accepted push allocates a slot, so duplicate addresses may coexist and lookup returns the youngest.

Decomposition:
- Shared package l2_pkg: ADDR_W/DATA_W defaults, the drain state enum {WB_IDLE, WB_WRITE}, and the entry struct {valid, addr, data}.
- One sub-module, wb_match, a combinational youngest-match priority search. Inputs: valids, addrs, wr_ptr, key. Outputs: hit, index. It is used for the lookup and, when coalescing is compiled in, for the push match.

Test Plan:
- Push A=0x10/D1, mem_rd_busy=0 -> mem_write rises 1 cycle later with addr 0x10/D1. Hold mem_ready low 5 cycles: outputs stay stable. Pulse mem_ready -> count 0, mem_write low, idle=1 the next cycle.
- Push 16 distinct entries with mem_rd_busy=1 -> full=1, count=16. A 17th push -> dropped, overflow=1. Release mem_rd_busy -> memory sees the 16 writes in push order; pointers wrap cleanly on a second fill of 16.
- Push 0x20/D1 then 0x20/D2, lk_addr=0x20 -> lk_hit=1, lk_data=D2 (WB_COALESCE_EN: count=1; without it: count=2). lk_addr=0x21 -> lk_hit=0, lk_data=0.
- With count=16 and FSM in WRITE, push at the same cycle as mem_ready -> push dropped, overflow=1, count=15 next cycle.
- mem_rd_busy=1 with 3 entries queued and flush=1 -> the drain starts anyway. Assert reset mid-WRITE -> mem_write=0, count=0 immediately (asynchronous).

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types for the L2 write-back buffer: default widths, drain state, entry layout.
package l2_pkg;

    localparam int L2_ADDR_W = 28;
    localparam int L2_DATA_W = 128;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_WRITE = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [L2_ADDR_W-1:0] addr;
        logic [L2_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/l2_write_buffer_match.sv
// Youngest-match search: scans backwards from wr_ptr so the entry written last wins.
module wb_match
    import l2_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = L2_ADDR_W,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  valids,
    input  logic [ADDR_W-1:0] addrs [DEPTH],
    input  logic [PW-1:0]     wr_ptr,
    input  logic [ADDR_W-1:0] key,
    output logic              hit,
    output logic [PW-1:0]     index
);

    logic [PW-1:0] idx;

    // Oldest slot (wr_ptr - DEPTH) is visited first, so later iterations override it.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        idx   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr - PW'(k);
            if (valids[idx] && (addrs[idx] == key)) begin
                hit   = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/l2_write_buffer.sv
// L2 victim write-back FIFO with read-miss forwarding and a two-state memory drain FSM.
// Optional in-place coalescing of repeated victim addresses: define WB_COALESCE_EN.
module l2_write_buffer
    import l2_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = L2_ADDR_W,
    parameter  int DATA_W = L2_DATA_W,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_hit,
    output logic [DATA_W-1:0] lk_data,
    input  logic              mem_rd_busy,
    input  logic              flush,
    output logic              idle,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready
);

    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, lk_idx, co_idx, wr_idx;
    logic [CW-1:0]     cnt;
    wb_state_e         state, state_next;
    logic              start, pop, alloc, drop, coalesce;

    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lookup (
        .valids (valid),
        .addrs  (addr_q),
        .wr_ptr (wr_ptr),
        .key    (lk_addr),
        .hit    (lk_hit),
        .index  (lk_idx)
    );

    assign lk_data = lk_hit ? data_q[lk_idx] : '0;

`ifdef WB_COALESCE_EN
    logic [DEPTH-1:0] co_valids;
    logic             co_hit;

    // The head being written to memory must not change under the in-flight write.
    always_comb begin
        co_valids = valid;
        if (state == WB_WRITE) co_valids[rd_ptr] = 1'b0;
    end

    wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_coalesce (
        .valids (co_valids),
        .addrs  (addr_q),
        .wr_ptr (wr_ptr),
        .key    (push_addr),
        .hit    (co_hit),
        .index  (co_idx)
    );

    assign coalesce = push && co_hit;
`else
    assign coalesce = 1'b0;
    assign co_idx   = '0;
`endif

    assign alloc  = push && !full && !coalesce;
    assign drop   = push && full && !coalesce;
    assign wr_idx = coalesce ? co_idx : wr_ptr;

    always_ff @(posedge clk) begin
        if (alloc || coalesce) begin
            addr_q[wr_idx] <= push_addr;
            data_q[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (alloc) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(alloc) - CW'(pop);
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WB_IDLE;
        else       state <= state_next;
    end

    // flush lets the drain start even while the L2 holds the memory port.
    always_comb begin
        state_next = state;
        case (state)
            WB_IDLE:  if (!empty && (!mem_rd_busy || flush)) state_next = WB_WRITE;
            WB_WRITE: if (mem_ready) state_next = WB_IDLE;
            default:  state_next = WB_IDLE;
        endcase
    end

    always_comb begin
        start = (state == WB_IDLE) && (state_next == WB_WRITE);
        pop   = (state == WB_WRITE) && mem_ready;
        idle  = empty && (state == WB_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            mem_write <= 1'b1;
            mem_addr  <= addr_q[rd_ptr];
            mem_wdata <= data_q[rd_ptr];
        end else if (pop) begin
            mem_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed bench for l2_write_buffer: drain handshake, full/overflow, lookup, flush, async reset.
module tb_l2_write_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset, push, mem_rd_busy, flush, mem_ready;
    logic [AW-1:0] push_addr, lk_addr;
    logic [DW-1:0] push_data;
    logic          full, empty, overflow, lk_hit, idle, mem_write;
    logic [CW-1:0] count;
    logic [DW-1:0] lk_data, mem_wdata;
    logic [AW-1:0] mem_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    l2_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (push_addr),
        .push_data   (push_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .lk_addr     (lk_addr),
        .lk_hit      (lk_hit),
        .lk_data     (lk_data),
        .mem_rd_busy (mem_rd_busy),
        .flush       (flush),
        .idle        (idle),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
        return {a, a, a, a, 16'hBEEF};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        push      = 1'b1;
        push_addr = a;
        push_data = d;
        tick();
        push = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input logic [AW-1:0] base, input int n);
        logic seen;
        for (int i = 0; i < n; i++) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                if (mem_write) seen = 1'b1;
                else tick();
            end
            chk("drain_start", 128'(seen), 128'(1));
            chk("drain_addr", 128'(mem_addr), 128'(base + AW'(i)));
            chk("drain_data", mem_wdata, dat(base + AW'(i)));
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; mem_rd_busy = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        push_addr = '0; push_data = '0; lk_addr = '0;
        tick(); tick();
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_empty", 128'(empty), 128'(1));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_mem_write", 128'(mem_write), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        reset = 1'b0;

        // single eviction and a stalled memory completion
        do_push(28'h10, dat(28'h10));
        chk("t1_count", 128'(count), 128'(1));
        chk("t1_write_early", 128'(mem_write), 128'(0));
        tick();
        chk("t1_write", 128'(mem_write), 128'(1));
        chk("t1_addr", 128'(mem_addr), 128'h10);
        chk("t1_data", mem_wdata, dat(28'h10));
        lk_addr = 28'h10;
        #1;
        chk("t1_lk_head", 128'(lk_hit), 128'(1));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_hold_write", 128'(mem_write), 128'(1));
            chk("t1_hold_addr", 128'(mem_addr), 128'h10);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("t1_done_count", 128'(count), 128'(0));
        chk("t1_done_write", 128'(mem_write), 128'(0));
        chk("t1_done_idle", 128'(idle), 128'(1));

        // fill to full with the port held, overflow, then drain in order twice
        mem_rd_busy = 1'b1;
        for (int i = 0; i < 16; i++) do_push(28'h100 + AW'(i), dat(28'h100 + AW'(i)));
        chk("t2_full", 128'(full), 128'(1));
        chk("t2_count", 128'(count), 128'(16));
        chk("t2_no_ovf", 128'(overflow), 128'(0));
        chk("t2_no_write", 128'(mem_write), 128'(0));
        do_push(28'h1FF, dat(28'h1FF));
        chk("t2_ovf", 128'(overflow), 128'(1));
        chk("t2_count_ovf", 128'(count), 128'(16));
        lk_addr = 28'h1FF;
        #1;
        chk("t2_lk_dropped", 128'(lk_hit), 128'(0));
        mem_rd_busy = 1'b0;
        drain(28'h100, 16);
        chk("t2_empty", 128'(empty), 128'(1));
        mem_rd_busy = 1'b1;
        for (int i = 0; i < 16; i++) do_push(28'h200 + AW'(i), dat(28'h200 + AW'(i)));
        chk("t2_full2", 128'(full), 128'(1));
        mem_rd_busy = 1'b0;
        drain(28'h200, 16);
        chk("t2_idle2", 128'(idle), 128'(1));

        // lookup returns the youngest duplicate
        do_reset();
        mem_rd_busy = 1'b1;
        do_push(28'h20, 128'h1111);
        do_push(28'h20, 128'h2222);
        lk_addr = 28'h20;
        #1;
        chk("t3_hit", 128'(lk_hit), 128'(1));
        chk("t3_data", lk_data, 128'h2222);
`ifdef WB_COALESCE_EN
        chk("t3_count", 128'(count), 128'(1));
`else
        chk("t3_count", 128'(count), 128'(2));
`endif
        lk_addr = 28'h21;
        #1;
        chk("t3_miss_hit", 128'(lk_hit), 128'(0));
        chk("t3_miss_data", lk_data, 128'(0));
        lk_addr   = 28'h30;
        push      = 1'b1;
        push_addr = 28'h30;
        push_data = 128'h3333;
        #1;
        chk("t3_same_cycle_push", 128'(lk_hit), 128'(0));
        tick();
        push = 1'b0;
        chk("t3_after_push", 128'(lk_hit), 128'(1));
        chk("t3_after_data", lk_data, 128'h3333);

        // push at full in the same cycle as a pop is still dropped
        do_reset();
        mem_rd_busy = 1'b1;
        for (int i = 0; i < 16; i++) do_push(28'h300 + AW'(i), dat(28'h300 + AW'(i)));
        mem_rd_busy = 1'b0;
        tick();
        chk("t4_write", 128'(mem_write), 128'(1));
        chk("t4_addr", 128'(mem_addr), 128'h300);
        push      = 1'b1;
        push_addr = 28'h3AA;
        push_data = dat(28'h3AA);
        mem_ready = 1'b1;
        tick();
        push      = 1'b0;
        mem_ready = 1'b0;
        chk("t4_ovf", 128'(overflow), 128'(1));
        chk("t4_count", 128'(count), 128'(15));
        chk("t4_full", 128'(full), 128'(0));
        lk_addr = 28'h3AA;
        #1;
        chk("t4_lk_dropped", 128'(lk_hit), 128'(0));

        // flush overrides mem_rd_busy; async reset kills the in-flight write
        do_reset();
        mem_rd_busy = 1'b1;
        for (int i = 0; i < 3; i++) do_push(28'h400 + AW'(i), dat(28'h400 + AW'(i)));
        tick(); tick();
        chk("t5_held", 128'(mem_write), 128'(0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_write", 128'(mem_write), 128'(1));
        chk("t5_flush_addr", 128'(mem_addr), 128'h400);
        lk_addr = 28'h400;
        #1;
        chk("t5_lk_inflight", 128'(lk_hit), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_write", 128'(mem_write), 128'(0));
        chk("t5_rst_count", 128'(count), 128'(0));
        chk("t5_rst_idle", 128'(idle), 128'(1));
        chk("t5_rst_lk", 128'(lk_hit), 128'(0));
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
